sync_fifo: RTL and testbench
============================

# sync_fifo

Single-clock, parametrised successor to the team's async FIFO. It keeps the same write/read handshake and flag set (`winc`/`rinc`, `wfull`/`awfull`, `rempty`/`arempty`) and adds:
- programmable almost-full/almost-empty thresholds;
- an occupancy count;
- a selectable first-word-fall-through (FWFT) read mode;
- sticky overflow/underflow error flags;
- a synchronous flush.

It is used for same-domain buffering in datapaths where the Gray-code pointer synchroniser is unnecessary.

## Interface
Parameters:
- `DSIZE`, 32, data width in bits.
- `ASIZE`, 4, address width; depth = 2**ASIZE.
- `AFULL_TH`, 2**ASIZE-2, `awfull` asserts when count >= `AFULL_TH`; legal range 1..2**ASIZE.
- `AEMPTY_TH`, 2, `arempty` asserts when count <= `AEMPTY_TH`; legal range 0..2**ASIZE-1.
- `FWFT`, 0, 0 = standard registered read, 1 = first-word-fall-through.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `flush`  in  1  synchronous clear of contents and pointers; sticky flags are kept.
- `winc`  in  1  write request.
- `wdata`  in  DSIZE  write data.
- `wfull`  out  1  FIFO full.
- `awfull`  out  1  almost full.
- `rinc`  in  1  read request.
- `rdata`  out  DSIZE  read data.
- `rempty`  out  1  FIFO empty.
- `arempty`  out  1  almost empty.
- `count`  out  ASIZE+1  current occupancy, 0..2**ASIZE.
- `overflow`  out  1  sticky: a write was attempted while full.
- `underflow`  out  1  sticky: a read was attempted while empty.

## Operation
- **Pointers.** `wptr` and `rptr` are ASIZE+1 bits wide, binary, and wrap modulo 2**(ASIZE+1).
  - `count` = `wptr` − `rptr` (ASIZE+1-bit subtraction).
  - `wfull` = (count == 2**ASIZE); `rempty` = (count == 0).
  - `awfull` and `arempty` are compares on `count`.
  - All five are decoded from registered state; there is no combinational path from `winc`/`rinc`.
- **Write acceptance.** A write is accepted iff `winc` && !`wfull`. The memory is written at `wptr[ASIZE-1:0]` and `wptr` increments.
- **Read acceptance.** A read is accepted iff `rinc` && !`rempty`, and `rptr` increments.
- **Rejected requests.**
  - `winc` while full: data is dropped and `overflow` is set.
  - `rinc` while empty: the pointer is unchanged, `rdata` holds, and `underflow` is set.
- **Simultaneous write and read.** Each request is evaluated independently against current flags.
  - When neither side is blocked, count is unchanged.
  - When full, the read is accepted, the write is rejected and `overflow` is set (there is no same-cycle pass-through).
  - When empty, the write is accepted, the read is rejected and `underflow` is set.
- **Standard mode (`FWFT`=0).** `rdata` is a register loaded with `mem[rptr]` on an accepted read. It holds otherwise.
- **FWFT mode (`FWFT`=1).** `rdata` = `mem[rptr[ASIZE-1:0]]` combinationally whenever !`rempty`, so `rinc` acts as a pop/acknowledge. `rdata` is don't-care while `rempty`.
- **Flush.** On `flush`: `wptr` = `rptr` = 0 and `count` = 0. Any `winc`/`rinc` in the same cycle is ignored and does not set sticky flags.
- **Reset.** On `rst`:
  - `wptr`, `rptr`, `count` = 0;
  - `rempty` = 1, `arempty` = 1, `wfull` = 0, `awfull` = 0;
  - `overflow` = `underflow` = 0;
  - `rdata` = 0 (standard mode).
  - `rst` has priority over `flush` and all requests.
  - A reset asserted mid-burst discards all contents; the memory array itself is not cleared.
- **Sticky flags.** `overflow` and `underflow` clear only on `rst`.

## Timing
- **Write to read visibility.** A write accepted at edge N makes `rempty` deassert after edge N.
  - FWFT: data is valid on `rdata` in the cycle after edge N (latency 1).
  - Standard: `rinc` in the cycle after edge N gives data on `rdata` after edge N+1 (latency 2 from the write).
- **Read to full.** A read accepted at edge N deasserts `wfull` after edge N, so a write can be accepted at edge N+1.
- **Flag and count updates.** `count` and all flags update exactly one edge after the causing request; there are no glitches between edges.
- **Sticky-flag timing.** `overflow`/`underflow` assert after the edge that samples the illegal request.

## Structure
- Package `sync_fifo_pkg`:
  - a `count_t` typedef helper (ASIZE+1 bit);
  - localparam `DEPTH` = 2**ASIZE;
  - a parameter-legality check function for the thresholds, used in elaboration assertions.
- Sub-module `fifo_mem`:
  - DSIZE × 2**ASIZE array;
  - one synchronous write port;
  - one asynchronous read port.
  - The top level owns pointers, flags, the `rdata` register and the sticky logic.

## Test plan
Configuration for all scenarios: DSIZE=32, ASIZE=4 (depth 16), AFULL_TH=14, AEMPTY_TH=2. Each scenario is run with FWFT=0 and with FWFT=1 unless stated.
- **Reset values.** Hold `rst` 2 cycles with `winc`=`rinc`=1 → `rempty`=1, `arempty`=1, `wfull`=0, `count`=0, `overflow`=`underflow`=0.
- **Fill, overflow and ordered drain.** Write 0x1000..0x100F (16 words), then one more write of 0xDEAD.
  - `awfull` asserts after the 14th write and `wfull` after the 16th; `count`=16.
  - `overflow`=1 after the 17th write and 0xDEAD is discarded.
  - Draining returns 0x1000..0x100F in order; `arempty` asserts at count 2 and `rempty` at 0.
- **Underflow.** With the FIFO empty, `rinc`=1 for one cycle → `underflow`=1, `count` stays 0, `rdata` unchanged (FWFT=0).
- **Simultaneous write/read.**
  - At count 8, assert `winc`=`rinc`=1 for 20 cycles → `count` stays 8, output order is preserved, and the pointers wrap past 31 without error.
  - When full, `winc`=`rinc`=1 → `count` becomes 15 and `overflow`=1.
- **FWFT latency.** With FWFT=1, write 0xA5A5A5A5 into the empty FIFO → the next cycle shows `rempty`=0 and `rdata`=0xA5A5A5A5 with no `rinc`.
- **Flush and mid-burst reset.**
  - At count 10 with `overflow`=1, pulse `flush` with `winc`=1 → `count`=0, `rempty`=1, `overflow` remains 1.
  - Pulse `rst` mid-burst → all outputs return to their reset values.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg
// Shared definitions for the single-clock FIFO:
//   DEPTH     - default FIFO depth, 2**ASIZE_DEF
//   count_t   - occupancy type for the default depth (ASIZE_DEF+1 bits)
//   fifo_params_ok() - legality check of the almost-full/almost-empty
//                      thresholds, evaluated at elaboration by sync_fifo
package sync_fifo_pkg;

  localparam int ASIZE_DEF = 4;
  localparam int DEPTH     = 2 ** ASIZE_DEF;

  typedef logic [ASIZE_DEF:0] count_t;

  // awfull threshold must be reachable (1..depth); arempty threshold must
  // leave at least one non-almost-empty level (0..depth-1).
  function automatic bit fifo_params_ok(input int asize, input int afull_th,
                                        input int aempty_th);
    int depth;
    depth = 2 ** asize;
    return (asize >= 1) &&
           (afull_th >= 1) && (afull_th <= depth) &&
           (aempty_th >= 0) && (aempty_th <= depth - 1);
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// fifo_mem
// Storage array for sync_fifo: DSIZE x 2**ASIZE words, one synchronous
// write port and one asynchronous (combinational) read port. The array is
// not reset; validity of its contents is tracked by the owner's pointers.
// Ports:
//   clk   - write clock
//   we    - write enable
//   waddr - write address
//   wdata - write data
//   raddr - read address
//   rdata - read data (combinational from raddr)
module fifo_mem #(
  parameter int DSIZE = 32,
  parameter int ASIZE = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [ASIZE-1:0] waddr,
  input  logic [DSIZE-1:0] wdata,
  input  logic [ASIZE-1:0] raddr,
  output logic [DSIZE-1:0] rdata
);

  logic [DSIZE-1:0] mem [2**ASIZE];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// sync_fifo
// Single-clock FIFO with programmable almost-full/almost-empty thresholds,
// occupancy count, optional first-word-fall-through read, sticky
// overflow/underflow flags and a synchronous flush.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   flush         - clears pointers/contents, keeps sticky flags
//   winc, wdata   - write request and data
//   wfull, awfull - full / almost full (count >= AFULL_TH)
//   rinc, rdata   - read request and data (registered, or FWFT view)
//   rempty        - empty
//   arempty       - almost empty (count <= AEMPTY_TH)
//   count         - occupancy 0..2**ASIZE
//   overflow      - sticky: write attempted while full
//   underflow     - sticky: read attempted while empty
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DSIZE     = 32,
  parameter int ASIZE     = 4,
  parameter int AFULL_TH  = 2**ASIZE - 2,
  parameter int AEMPTY_TH = 2,
  parameter int FWFT      = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             winc,
  input  logic [DSIZE-1:0] wdata,
  output logic             wfull,
  output logic             awfull,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             rempty,
  output logic             arempty,
  output logic [ASIZE:0]   count,
  output logic             overflow,
  output logic             underflow
);

  if (!fifo_params_ok(ASIZE, AFULL_TH, AEMPTY_TH)) begin : g_bad_params
    $fatal(1, "sync_fifo: AFULL_TH/AEMPTY_TH out of range for ASIZE");
  end

  localparam logic [ASIZE:0] FULL_CNT   = (ASIZE+1)'(2**ASIZE);
  localparam logic [ASIZE:0] AFULL_CNT  = (ASIZE+1)'(AFULL_TH);
  localparam logic [ASIZE:0] AEMPTY_CNT = (ASIZE+1)'(AEMPTY_TH);

  logic [ASIZE:0]   wptr;
  logic [ASIZE:0]   rptr;
  logic [DSIZE-1:0] mem_rdata;
  logic [DSIZE-1:0] rdata_q;
  logic             wr_acc;
  logic             rd_acc;

  // Occupancy and all flags decode from the pointer registers only, so they
  // change exactly one edge after the causing request.
  assign count   = wptr - rptr;
  assign wfull   = (count == FULL_CNT);
  assign rempty  = (count == '0);
  assign awfull  = (count >= AFULL_CNT);
  assign arempty = (count <= AEMPTY_CNT);

  // Each side is judged against the current flags; a full FIFO never passes
  // a same-cycle write through to the read side.
  assign wr_acc = winc && !wfull && !flush && !rst;
  assign rd_acc = rinc && !rempty && !flush && !rst;

  fifo_mem #(
    .DSIZE (DSIZE),
    .ASIZE (ASIZE)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wptr[ASIZE-1:0]),
    .wdata (wdata),
    .raddr (rptr[ASIZE-1:0]),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      rdata_q   <= '0;
    end else if (flush) begin
      // Requests in a flush cycle are ignored entirely, including the
      // sticky error detection.
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_acc) wptr <= wptr + 1'b1;
      if (rd_acc) begin
        rptr    <= rptr + 1'b1;
        rdata_q <= mem_rdata;
      end
      if (winc && wfull)  overflow  <= 1'b1;
      if (rinc && rempty) underflow <= 1'b1;
    end
  end

  // FWFT exposes the head word directly; rinc then acts as an acknowledge.
  if (FWFT != 0) begin : g_fwft
    assign rdata = mem_rdata;
  end else begin : g_std
    assign rdata = rdata_q;
  end

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo
// Drives one standard-mode and one FWFT-mode sync_fifo with identical
// stimulus and compares both against a queue-based reference model.
module tb_sync_fifo;
  import sync_fifo_pkg::*;

  localparam int DSIZE = 32;
  localparam int ASIZE = 4;

  logic             clk = 1'b0;
  logic             rst, flush, winc, rinc;
  logic [DSIZE-1:0] wdata;

  logic             wfull0, awfull0, rempty0, arempty0, ovf0, unf0;
  logic             wfull1, awfull1, rempty1, arempty1, ovf1, unf1;
  logic [DSIZE-1:0] rdata0, rdata1;
  logic [ASIZE:0]   count0, count1;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [DSIZE-1:0] q[$];
  logic             m_ovf, m_unf;
  logic [DSIZE-1:0] m_last_rd;

  always #5 clk = ~clk;

  sync_fifo #(.DSIZE(DSIZE), .ASIZE(ASIZE), .AFULL_TH(14), .AEMPTY_TH(2),
              .FWFT(0)) dut_std (
    .clk(clk), .rst(rst), .flush(flush), .winc(winc), .wdata(wdata),
    .wfull(wfull0), .awfull(awfull0), .rinc(rinc), .rdata(rdata0),
    .rempty(rempty0), .arempty(arempty0), .count(count0),
    .overflow(ovf0), .underflow(unf0)
  );

  sync_fifo #(.DSIZE(DSIZE), .ASIZE(ASIZE), .AFULL_TH(14), .AEMPTY_TH(2),
              .FWFT(1)) dut_fwft (
    .clk(clk), .rst(rst), .flush(flush), .winc(winc), .wdata(wdata),
    .wfull(wfull1), .awfull(awfull1), .rinc(rinc), .rdata(rdata1),
    .rempty(rempty1), .arempty(arempty1), .count(count1),
    .overflow(ovf1), .underflow(unf1)
  );

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    count_t exp_cnt;
    exp_cnt = count_t'(q.size());
    check("count_std",    64'(count0),   64'(exp_cnt));
    check("count_fwft",   64'(count1),   64'(exp_cnt));
    check("rempty_std",   64'(rempty0),  64'(q.size() == 0));
    check("rempty_fwft",  64'(rempty1),  64'(q.size() == 0));
    check("wfull_std",    64'(wfull0),   64'(q.size() == DEPTH));
    check("wfull_fwft",   64'(wfull1),   64'(q.size() == DEPTH));
    check("awfull_std",   64'(awfull0),  64'(q.size() >= 14));
    check("awfull_fwft",  64'(awfull1),  64'(q.size() >= 14));
    check("arempty_std",  64'(arempty0), 64'(q.size() <= 2));
    check("arempty_fwft", 64'(arempty1), 64'(q.size() <= 2));
    check("ovf_std",      64'(ovf0),     64'(m_ovf));
    check("ovf_fwft",     64'(ovf1),     64'(m_ovf));
    check("unf_std",      64'(unf0),     64'(m_unf));
    check("unf_fwft",     64'(unf1),     64'(m_unf));
    check("rdata_std",    64'(rdata0),   64'(m_last_rd));
    if (q.size() > 0) check("rdata_fwft", 64'(rdata1), 64'(q[0]));
  endtask

  // One clock cycle: drive inputs, advance the model at the edge, then
  // compare every output half a cycle later.
  task automatic step(input logic r, input logic fl, input logic w,
                      input logic rd, input logic [DSIZE-1:0] d);
    logic full, empty;
    rst = r; flush = fl; winc = w; rinc = rd; wdata = d;
    @(posedge clk);
    if (r) begin
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_last_rd = '0;
    end else if (fl) begin
      q.delete();
    end else begin
      full  = (q.size() == DEPTH);
      empty = (q.size() == 0);
      if (w && full)  m_ovf = 1'b1;
      if (rd && empty) m_unf = 1'b1;
      if (rd && !empty) m_last_rd = q.pop_front();
      if (w && !full) q.push_back(d);
    end
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    m_ovf = 1'b0; m_unf = 1'b0; m_last_rd = '0;

    // reset held two cycles with both requests active
    step(1, 0, 1, 1, 32'h1234);
    step(1, 0, 1, 1, 32'h5678);

    // fill 16, overflow write, ordered drain, underflow
    for (int i = 0; i < 16; i++) step(0, 0, 1, 0, 32'h1000 + i);
    step(0, 0, 1, 0, 32'hDEAD);
    for (int i = 0; i < 16; i++) step(0, 0, 0, 1, '0);
    step(0, 0, 0, 1, '0);

    // count 8 then 20 simultaneous cycles; pointers wrap past 31
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0, 32'h2000 + i);
    for (int i = 0; i < 20; i++) step(0, 0, 1, 1, 32'h3000 + i);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1, '0);

    // simultaneous request while full
    step(1, 0, 0, 0, '0);
    for (int i = 0; i < 16; i++) step(0, 0, 1, 0, 32'h4000 + i);
    step(0, 0, 1, 1, 32'hBEEF);
    check("full_simul_count", 64'(count0), 64'd15);

    // FWFT latency into an empty FIFO
    step(1, 0, 0, 0, '0);
    step(0, 0, 1, 0, 32'hA5A5A5A5);
    check("fwft_latency_data", 64'(rdata1), 64'hA5A5A5A5);
    step(0, 0, 0, 0, '0);
    step(0, 0, 0, 1, '0);

    // flush at count 10 with overflow set
    step(1, 0, 0, 0, '0);
    for (int i = 0; i < 17; i++) step(0, 0, 1, 0, 32'h5000 + i);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1, '0);
    step(0, 1, 1, 0, 32'h6000);
    check("flush_ovf_kept", 64'(ovf1), 64'd1);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 32'h7000 + i);

    // reset in the middle of a burst, then normal use again
    for (int i = 0; i < 5; i++) step(0, 0, 1, (i > 2), 32'h8000 + i);
    step(1, 0, 1, 1, 32'h9999);
    step(0, 0, 1, 0, 32'h9000);
    step(0, 0, 0, 1, '0);
    step(0, 0, 0, 0, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
